disp_buf_writer: RTL and testbench

//  Write-side producer for the two dual-port display RAMs read by the VGA image controller.

---
 rtl/disp_buf_writer_pkg.sv | 40 ++++
 rtl/disp_buf_writer_if.sv | 37 +++
 rtl/disp_buf_writer_mag_scale_sat.sv | 21 ++
 rtl/disp_buf_writer.sv | 195 +++++++++++++++++++
 tb/tb_disp_buf_writer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_buf_writer_pkg.sv
// disp_buf_writer_pkg
//   Shared definitions for the display-buffer writer: time-capture FSM state
//   encoding, default geometry/scaling constants, bus widths and the bar-height
//   saturation helper used by the frequency path.
package disp_buf_writer_pkg;

  // Time-capture FSM states
  typedef enum logic [1:0] {
    S_ARM       = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_HOLDOFF   = 2'd3
  } timeState_e;

  localparam int TIME_DEPTH_DEF   = 32'd640;
  localparam int NUM_BINS_DEF     = 32'd80;
  localparam int TRIG_HYST_DEF    = 32'd8;
  localparam int TRIG_TIMEOUT_DEF = 32'd4800;
  localparam int HOLDOFF_DEF      = 32'd2400;
  localparam int MAG_SHIFT_DEF    = 32'd6;
  localparam int FREQ_MAX_DEF     = 32'd230;

  localparam int ADDR_W = 32'd10;
  localparam int CNT_W  = 32'd13;
  localparam int SMPL_W = 32'd8;
  localparam int MAG_W  = 32'd16;

  // Clamp an already-scaled magnitude to the bar-height ceiling
  function automatic logic [7:0] satHeight(input logic [15:0] scaled,
                                           input logic [15:0] ceiling);
    logic [7:0] h;
    if (scaled > ceiling) begin
      h = ceiling[7:0];
    end else begin
      h = scaled[7:0];
    end
    return h;
  endfunction

endpackage

// File: rtl/disp_buf_writer_if.sv
// disp_buf_writer_if
//   Bundles the sample stream, FFT beat stream, freeze control and both RAM
//   port-A write buses of the display-buffer writer.
//   master : the writer (consumes samples/beats, drives RAM ports + frameDone)
//   slave  : the environment (sample source, FFT, Picoblaze, RAMs)
interface disp_buf_writer_if;
  import disp_buf_writer_pkg::*;

  logic                smplStrobe;
  logic [SMPL_W-1:0]   smplData;
  logic                freeze;
  logic                fftValid;
  logic [ADDR_W-1:0]   fftIndex;
  logic [MAG_W-1:0]    fftMag;

  logic                enaTime;
  logic                weaTime;
  logic [ADDR_W-1:0]   addraTime;
  logic [SMPL_W-1:0]   dinaTime;
  logic                weaFreq;
  logic [ADDR_W-1:0]   addraFreq;
  logic [7:0]          dinaFreq;
  logic                frameDone;

  modport master (
    input  smplStrobe, smplData, freeze, fftValid, fftIndex, fftMag,
    output enaTime, weaTime, addraTime, dinaTime,
           weaFreq, addraFreq, dinaFreq, frameDone
  );

  modport slave (
    output smplStrobe, smplData, freeze, fftValid, fftIndex, fftMag,
    input  enaTime, weaTime, addraTime, dinaTime,
           weaFreq, addraFreq, dinaFreq, frameDone
  );

endinterface

// File: rtl/disp_buf_writer_mag_scale_sat.sv
// mag_scale_sat
//   Combinational FFT magnitude scaler: right-shifts the magnitude and clamps
//   it to the bar-height ceiling. The parent registers the result.
//   mag    in  16  unsigned bin magnitude
//   height out  8  scaled, saturated bar height
module mag_scale_sat
  import disp_buf_writer_pkg::*;
#(
  parameter int MAG_SHIFT = MAG_SHIFT_DEF,
  parameter int FREQ_MAX  = FREQ_MAX_DEF
) (
  input  logic [MAG_W-1:0] mag,
  output logic [7:0]       height
);

  // Shift then saturate to the display ceiling
  always_comb begin
    height = satHeight(mag >> MAG_SHIFT, 16'(FREQ_MAX));
  end

endmodule

// File: rtl/disp_buf_writer.sv
// disp_buf_writer
//   Write-side producer for the VGA time and frequency display RAMs (port A).
//   Time path: triggered capture of TIME_DEPTH signed samples with hysteresis
//   arming, auto-trigger timeout and post-frame holdoff.
//   Freq path: one-cycle pipeline scaling/saturating FFT magnitudes into bars.
//   ck100MHz  in  system clock
//   reset     in  synchronous active-high reset
//   bus       master modport: sample/FFT inputs, freeze, RAM write ports,
//             frameDone pulse. All outputs registered.
module disp_buf_writer
  import disp_buf_writer_pkg::*;
#(
  parameter int TIME_DEPTH   = TIME_DEPTH_DEF,
  parameter int NUM_BINS     = NUM_BINS_DEF,
  parameter int TRIG_HYST    = TRIG_HYST_DEF,
  parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF,
  parameter int HOLDOFF      = HOLDOFF_DEF,
  parameter int MAG_SHIFT    = MAG_SHIFT_DEF,
  parameter int FREQ_MAX     = FREQ_MAX_DEF
) (
  input  logic                ck100MHz,
  input  logic                reset,
  disp_buf_writer_if.master   bus
);

  localparam logic signed [SMPL_W-1:0] HYST_POS = SMPL_W'(TRIG_HYST);
  localparam logic signed [SMPL_W-1:0] HYST_NEG = SMPL_W'(-TRIG_HYST);

  timeState_e           state_r;
  timeState_e           stateNext_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cntNext_s;

  logic signed [SMPL_W-1:0] sample_s;
  logic                 armHit_s;
  logic                 trigHit_s;
  logic                 timeoutHit_s;
  logic                 holdDone_s;
  logic                 lastAddr_s;

  logic                 wrTime_s;
  logic [ADDR_W-1:0]    wrAddr_s;
  logic                 frameLast_s;

  logic                 freqHit_s;
  logic [7:0]           height_s;

  logic                 enaTime_r;
  logic                 weaTime_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [SMPL_W-1:0]    dinaTime_r;
  logic                 frameDone_r;
  logic                 weaFreq_r;
  logic [ADDR_W-1:0]    addraFreq_r;
  logic [7:0]           dinaFreq_r;

  assign sample_s     = $signed(bus.smplData);
  assign armHit_s     = !bus.freeze && (sample_s < HYST_NEG);
  assign trigHit_s    = sample_s >= HYST_POS;
  // One counter serves both the trigger timeout and the holdoff interval
  assign timeoutHit_s = cnt_r == CNT_W'(TRIG_TIMEOUT - 1);
  assign holdDone_s   = cnt_r == CNT_W'(HOLDOFF - 1);
  // The strobe that sees this writes the final address of the frame
  assign lastAddr_s   = addr_r == ADDR_W'(TIME_DEPTH - 2);
  assign freqHit_s    = bus.fftValid && (bus.fftIndex < ADDR_W'(NUM_BINS));

  mag_scale_sat #(
    .MAG_SHIFT (MAG_SHIFT),
    .FREQ_MAX  (FREQ_MAX)
  ) uScale (
    .mag    (bus.fftMag),
    .height (height_s)
  );

  // FSM state and shared timeout/holdoff counter register
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      state_r <= S_ARM;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Next-state decode, evaluated only on sample strobes
  always_comb begin
    stateNext_s = state_r;
    if (bus.smplStrobe) begin
      case (state_r)
        S_ARM: begin
          if (armHit_s) stateNext_s = S_WAIT_TRIG;
          else          stateNext_s = S_ARM;
        end
        S_WAIT_TRIG: begin
          if (trigHit_s || timeoutHit_s) stateNext_s = S_CAPTURE;
          else                           stateNext_s = S_WAIT_TRIG;
        end
        S_CAPTURE: begin
          if (lastAddr_s) stateNext_s = S_HOLDOFF;
          else            stateNext_s = S_CAPTURE;
        end
        S_HOLDOFF: begin
          if (holdDone_s) stateNext_s = S_ARM;
          else            stateNext_s = S_HOLDOFF;
        end
        default: stateNext_s = S_ARM;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // Write request, address, frame-end flag and counter update per strobe
  always_comb begin
    wrTime_s    = 1'b0;
    wrAddr_s    = addr_r;
    frameLast_s = 1'b0;
    cntNext_s   = cnt_r;
    if (bus.smplStrobe) begin
      case (state_r)
        S_ARM: begin
          // Held at zero so WAIT_TRIG always starts a fresh timeout
          cntNext_s = {CNT_W{1'b0}};
        end
        S_WAIT_TRIG: begin
          if (trigHit_s || timeoutHit_s) begin
            wrTime_s  = 1'b1;
            wrAddr_s  = {ADDR_W{1'b0}};
            cntNext_s = {CNT_W{1'b0}};
          end else begin
            cntNext_s = cnt_r + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          wrTime_s    = 1'b1;
          wrAddr_s    = addr_r + ADDR_W'(1);
          frameLast_s = lastAddr_s;
          cntNext_s   = {CNT_W{1'b0}};
        end
        S_HOLDOFF: begin
          if (holdDone_s) cntNext_s = {CNT_W{1'b0}};
          else            cntNext_s = cnt_r + CNT_W'(1);
        end
        default: cntNext_s = {CNT_W{1'b0}};
      endcase
    end else begin
      cntNext_s = cnt_r;
    end
  end

  // Time RAM port-A output registers; address and data hold between writes
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      enaTime_r   <= 1'b0;
      weaTime_r   <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      dinaTime_r  <= {SMPL_W{1'b0}};
      frameDone_r <= 1'b0;
    end else begin
      enaTime_r   <= wrTime_s;
      weaTime_r   <= wrTime_s;
      frameDone_r <= frameLast_s;
      addr_r      <= wrAddr_s;
      if (wrTime_s) begin
        dinaTime_r <= bus.smplData;
      end
    end
  end

  // Frequency RAM port-A output registers (one-cycle pipeline)
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      weaFreq_r   <= 1'b0;
      addraFreq_r <= {ADDR_W{1'b0}};
      dinaFreq_r  <= 8'd0;
    end else begin
      weaFreq_r <= freqHit_s;
      if (freqHit_s) begin
        addraFreq_r <= bus.fftIndex;
        dinaFreq_r  <= height_s;
      end
    end
  end

  assign bus.enaTime   = enaTime_r;
  assign bus.weaTime   = weaTime_r;
  assign bus.addraTime = addr_r;
  assign bus.dinaTime  = dinaTime_r;
  assign bus.frameDone = frameDone_r;
  assign bus.weaFreq   = weaFreq_r;
  assign bus.addraFreq = addraFreq_r;
  assign bus.dinaFreq  = dinaFreq_r;

endmodule

// File: tb/tb_disp_buf_writer.sv
// tb_disp_buf_writer
//   Randomized self-checking bench for disp_buf_writer. A transaction-level
//   model (per-strobe phase/countdown bookkeeping and plain arithmetic for the
//   bar heights) predicts every RAM write; each scenario task compares the
//   DUT outputs against it cycle by cycle plus a few directed checks.
module tb_disp_buf_writer;

  logic clk = 1'b0;
  logic rst;
  disp_buf_writer_if bus();

  disp_buf_writer dut (
    .ck100MHz (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference model state: 0 idle/armable, 1 waiting for trigger,
  // 2 capturing, 3 holding off
  int phase;
  int waitSeen;
  int capIdx;
  int holdLeft;
  int framesModel;
  logic       expWea, expDone;
  logic [9:0] expAddr;
  logic [7:0] expData;
  logic       expFW;
  logic [9:0] expFA;
  logic [7:0] expFD;

  function automatic logic [20:0] obsTime();
    return {bus.enaTime, bus.weaTime, bus.frameDone, bus.addraTime,
            bus.weaTime ? bus.dinaTime : 8'h00};
  endfunction

  function automatic logic [20:0] wantTime();
    return {expWea, expWea, expDone, expAddr, expWea ? expData : 8'h00};
  endfunction

  function automatic logic [18:0] obsFreq();
    return {bus.weaFreq, bus.weaFreq ? bus.addraFreq : 10'd0,
            bus.weaFreq ? bus.dinaFreq : 8'h00};
  endfunction

  function automatic logic [18:0] wantFreq();
    return {expFW, expFW ? expFA : 10'd0, expFW ? expFD : 8'h00};
  endfunction

  function automatic logic [39:0] obsAll();
    return {bus.enaTime, bus.weaTime, bus.addraTime, bus.dinaTime,
            bus.weaFreq, bus.addraFreq, bus.dinaFreq, bus.frameDone};
  endfunction

  function automatic logic [7:0] sineSmp(input int k);
    real r;
    int  v;
    r = 100.0 * $sin(6.283185307 * real'(k) / 40.0);
    v = $rtoi(r) + int'($urandom_range(0, 4)) - 2;
    return 8'(v);
  endfunction

  task automatic modelReset();
    phase = 0; waitSeen = 0; capIdx = 0; holdLeft = 0;
    expWea = 1'b0; expDone = 1'b0; expAddr = 10'd0; expData = 8'h00;
    expFW = 1'b0; expFA = 10'd0; expFD = 8'h00;
  endtask

  task automatic idleInputs();
    bus.smplStrobe = 1'b0; bus.smplData = 8'h00;
    bus.fftValid = 1'b0; bus.fftIndex = 10'd0; bus.fftMag = 16'h0000;
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge
  task automatic step(input bit st, input logic [7:0] d, input bit fv,
                      input logic [9:0] idx, input logic [15:0] mag);
    int sv;
    int s;
    bus.smplStrobe = st; bus.smplData = d;
    bus.fftValid = fv; bus.fftIndex = idx; bus.fftMag = mag;
    expWea = 1'b0; expDone = 1'b0;
    if (st) begin
      sv = int'($signed(d));
      if (phase == 0) begin
        if (!bus.freeze && sv < -8) begin phase = 1; waitSeen = 0; end
      end else if (phase == 1) begin
        waitSeen++;
        if (sv >= 8 || waitSeen == 4800) begin
          expWea = 1'b1; expAddr = 10'd0; expData = d; capIdx = 1; phase = 2;
        end
      end else if (phase == 2) begin
        expWea = 1'b1; expAddr = 10'(capIdx); expData = d;
        if (capIdx == 639) begin
          expDone = 1'b1; framesModel++; phase = 3; holdLeft = 2400;
        end else begin
          capIdx++;
        end
      end else begin
        holdLeft--;
        if (holdLeft == 0) phase = 0;
      end
    end
    expFW = fv && (idx < 10'd80);
    if (expFW) begin
      s = int'(mag) / 64;
      expFA = idx;
      expFD = 8'((s > 230) ? 230 : s);
    end
    @(posedge clk); #1;
    bus.smplStrobe = 1'b0; bus.fftValid = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.freeze = 1'b0;
    bus.smplStrobe = 1'b1; bus.smplData = 8'hCE;
    bus.fftValid = 1'b1; bus.fftIndex = 10'd3; bus.fftMag = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (obsAll() !== 40'd0) begin
      nBad++; $display("FAIL reset_outputs: got %h want %h", obsAll(), 40'd0);
    end
    rst = 1'b0; idleInputs(); modelReset();
    step(1'b0, 8'h00, 1'b0, 10'd0, 16'h0000);
    nCmp++;
    if (obsTime() !== wantTime() || obsFreq() !== wantFreq()) begin
      nBad++; $display("FAIL reset_idle: got %h/%h want %h/%h",
                       obsTime(), obsFreq(), wantTime(), wantFreq());
    end
  endtask

  task automatic test_sine();
    int sk = 0;
    int k0;
    int doneObs = 0;
    bit st;
    doReset(); bus.freeze = 1'b0;
    k0 = int'($urandom_range(0, 39));
    for (int c = 0; c < 8000 && sk < 3200; c++) begin
      st = ($urandom_range(0, 3) != 0);
      step(st, sineSmp(k0 + sk), 1'b0, 10'd0, 16'h0000);
      if (st) sk++;
      nCmp++;
      if (obsTime() !== wantTime()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL sine_time cyc %0d: got %h want %h", c, obsTime(), wantTime());
      end
      if (bus.frameDone === 1'b1) doneObs++;
      if (expWea && expAddr == 10'd0) begin
        nCmp++;
        if (!($signed(bus.dinaTime) >= 8'sd8)) begin
          nBad++; $display("FAIL sine_addr0_data: got %0d want >= 8", $signed(bus.dinaTime));
        end
      end
    end
    nCmp++;
    if (doneObs !== 1) begin
      nBad++; $display("FAIL sine_frame_count: got %0d want 1", doneObs);
    end
  endtask

  task automatic test_timeout();
    int sk = 0;
    int cur;
    int firstWr = -1;
    int n50 = 0;
    bit st;
    logic [7:0] d;
    doReset(); bus.freeze = 1'b0;
    for (int c = 0; c < 14000 && sk < 7900; c++) begin
      st = ($urandom_range(0, 3) != 0);
      if (sk == 0)         d = 8'hEC;
      else if (sk <= 4800) d = 8'd5;
      else if (sk <= 5439) d = 8'd50;
      else                 d = 8'hEC;
      cur = sk;
      step(st, d, 1'b0, 10'd0, 16'h0000);
      if (st) sk++;
      nCmp++;
      if (obsTime() !== wantTime()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL timeout_time cyc %0d: got %h want %h", c, obsTime(), wantTime());
      end
      if (bus.weaTime === 1'b1 && firstWr < 0) firstWr = cur;
      if (bus.weaTime === 1'b1 && bus.dinaTime === 8'h32) n50++;
    end
    nCmp++;
    if (firstWr !== 4800) begin
      nBad++; $display("FAIL timeout_forced_strobe: got %0d want 4800", firstWr);
    end
    nCmp++;
    if (n50 !== 639) begin
      nBad++; $display("FAIL timeout_data_0x32_writes: got %0d want 639", n50);
    end
  endtask

  task automatic test_freeze();
    int stage = 0;
    int sk = 0;
    int cnt = 0;
    int doneObs = 0;
    int frozenWr = 0;
    bit sawRestart = 1'b0;
    bit st;
    doReset(); bus.freeze = 1'b0;
    for (int c = 0; c < 20000 && stage < 4; c++) begin
      st = ($urandom_range(0, 3) != 0);
      step(st, sineSmp(sk), 1'b0, 10'd0, 16'h0000);
      if (st) sk++;
      nCmp++;
      if (obsTime() !== wantTime()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL freeze_time cyc %0d: got %h want %h", c, obsTime(), wantTime());
      end
      if (bus.frameDone === 1'b1) doneObs++;
      case (stage)
        0: if (expWea && expAddr == 10'd300) begin bus.freeze = 1'b1; stage = 1; end
        1: if (phase == 0) begin stage = 2; cnt = 0; end
        2: begin
          if (bus.weaTime === 1'b1) frozenWr++;
          if (st) cnt++;
          if (cnt == 300) begin
            nCmp++;
            if (doneObs !== 1) begin
              nBad++; $display("FAIL freeze_frame_completed: got %0d want 1", doneObs);
            end
            bus.freeze = 1'b0; stage = 3; cnt = 0;
          end
        end
        default: begin
          if (bus.weaTime === 1'b1 && bus.addraTime === 10'd0) sawRestart = 1'b1;
          if (st) cnt++;
          if (cnt == 200) stage = 4;
        end
      endcase
    end
    nCmp++;
    if (stage !== 4) begin
      nBad++; $display("FAIL freeze_progress: got stage %0d want 4", stage);
    end
    nCmp++;
    if (frozenWr !== 0) begin
      nBad++; $display("FAIL freeze_writes_while_frozen: got %0d want 0", frozenWr);
    end
    nCmp++;
    if (sawRestart !== 1'b1) begin
      nBad++; $display("FAIL freeze_restart_addr0: got %b want 1", sawRestart);
    end
  endtask

  task automatic test_reset_mid();
    int sk = 0;
    bit st;
    bit hit = 1'b0;
    int firstAddr = -1;
    doReset(); bus.freeze = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      st = ($urandom_range(0, 3) != 0);
      step(st, sineSmp(sk), 1'b0, 10'd0, 16'h0000);
      if (st) sk++;
      nCmp++;
      if (obsTime() !== wantTime()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL rstmid_time cyc %0d: got %h want %h", c, obsTime(), wantTime());
      end
      if (expWea && expAddr == 10'd200) hit = 1'b1;
    end
    rst = 1'b1;
    bus.smplStrobe = 1'b1; bus.smplData = 8'hCE;
    bus.fftValid = 1'b1; bus.fftIndex = 10'd4; bus.fftMag = 16'h4000;
    @(posedge clk); #1;
    nCmp++;
    if (!hit || obsAll() !== 40'd0) begin
      nBad++; $display("FAIL rstmid_outputs: got %h (reached %b) want 0", obsAll(), hit);
    end
    rst = 1'b0; idleInputs(); modelReset();
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) != 0);
      step(st, sineSmp(sk), 1'b0, 10'd0, 16'h0000);
      if (st) sk++;
      nCmp++;
      if (obsTime() !== wantTime()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL rstmid_after cyc %0d: got %h want %h", c, obsTime(), wantTime());
      end
      if (bus.weaTime === 1'b1 && firstAddr < 0) firstAddr = int'(bus.addraTime);
    end
    nCmp++;
    if (firstAddr !== 0) begin
      nBad++; $display("FAIL rstmid_restart_addr: got %0d want 0", firstAddr);
    end
  endtask

  task automatic test_freq();
    logic [9:0]  dIdx [4] = '{10'd0, 10'd5, 10'd79, 10'd80};
    logic [15:0] dMag [4] = '{16'h0000, 16'h0C80, 16'hFFFF, 16'h1234};
    logic        dWe  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  dDat [4] = '{8'd0, 8'd50, 8'd230, 8'd0};
    bit fv;
    logic [15:0] mag;
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, dIdx[i], dMag[i]);
      nCmp++;
      if (bus.weaFreq !== dWe[i] ||
          (dWe[i] && (bus.addraFreq !== dIdx[i] || bus.dinaFreq !== dDat[i]))) begin
        nBad++;
        $display("FAIL freq_directed idx %0d: got we=%b addr=%0d data=%0d want we=%b data=%0d",
                 dIdx[i], bus.weaFreq, bus.addraFreq, bus.dinaFreq, dWe[i], dDat[i]);
      end
      step(1'b0, 8'h00, 1'b0, 10'd0, 16'h0000);
      nCmp++;
      if (bus.weaFreq !== 1'b0) begin
        nBad++; $display("FAIL freq_single_cycle idx %0d: got we=%b want 0", dIdx[i], bus.weaFreq);
      end
    end
    for (int c = 0; c < 300; c++) begin
      fv  = ($urandom_range(0, 3) != 0);
      mag = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535))
                                        : 16'($urandom_range(0, 16000));
      step(1'b0, 8'h00, fv, 10'($urandom_range(0, 95)), mag);
      nCmp++;
      if (obsFreq() !== wantFreq()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL freq_random cyc %0d: got %h want %h", c, obsFreq(), wantFreq());
      end
    end
  endtask

  task automatic test_back_to_back();
    int bothObs = 0;
    int bothExp = 0;
    doReset(); bus.freeze = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      step(1'b1, sineSmp(c), 1'b1, 10'($urandom_range(0, 90)),
           16'($urandom_range(0, 65535)));
      nCmp++;
      if (obsTime() !== wantTime() || obsFreq() !== wantFreq()) begin
        nBad++;
        if (nBad <= 20) $display("FAIL b2b cyc %0d: got %h/%h want %h/%h",
                                 c, obsTime(), obsFreq(), wantTime(), wantFreq());
      end
      if (bus.weaTime === 1'b1 && bus.weaFreq === 1'b1) bothObs++;
      if (expWea && expFW) bothExp++;
    end
    nCmp++;
    if (bothObs !== bothExp) begin
      nBad++; $display("FAIL b2b_dual_writes: got %0d want %0d", bothObs, bothExp);
    end
  endtask

  initial begin
    framesModel = 0;
    rst = 1'b1;
    bus.freeze = 1'b0;
    idleInputs();
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_sine();
    test_timeout();
    test_freeze();
    test_reset_mid();
    test_freq();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
